// File: rtl/packet_receive_buffer_pkg.sv
// Shared flit and packet types for the receive path.
// Two packages: types (flit format) and packet_types (reassembled packet element).
package types;
  localparam int LEN_W     = 4;
  localparam int PAYLOAD_W = 32;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    TAIL = 2'd2,
    NOPE = 2'd3
  } flittype_t;

  typedef struct packed {
    logic [1:0]           flittype;
    logic [7:0]           src_id;
    logic [7:0]           dst_id;
    logic [LEN_W-1:0]     length;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  // XOR of all payload bytes, the per-flit contribution to the running checksum.
  function automatic logic [7:0] fold_bytes(input logic [PAYLOAD_W-1:0] p);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < PAYLOAD_W / 8; i++) begin
      x = x ^ p[i*8 +: 8];
    end
    return x;
  endfunction
endpackage

package packet_types;
  localparam int MAX_BODY = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } rx_state_t;

  typedef struct packed {
    types::flit_t                         head;
    types::flit_t [MAX_BODY-1:0]          body;
    logic         [types::LEN_W-1:0]      count;
  } packet_element_t;
endpackage

// File: rtl/packet_receive_checksum.sv
// Running 8-bit XOR accumulator over flit payload bytes; used only when
// PACKET_RECEIVE_CHECKSUM_EN is defined.
module packet_receive_checksum
  import types::*;
(
  input  logic                 nocclk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 update,
  input  logic [PAYLOAD_W-1:0] data,
  input  logic [7:0]           expected,
  output logic                 match
);
  logic [7:0] acc_q, acc_d;

  // clear and update together restart the sum with the current flit
  always_comb begin
    acc_d = clear ? 8'h00 : acc_q;
    if (update) begin
      acc_d = acc_d ^ fold_bytes(data);
    end
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign match = (acc_q == expected);
endmodule

// File: rtl/packet_receive_buffer.sv
// Reassembles one HEAD/BODY/TAIL flit stream into a packet element and holds it
// until the controller consumes it. Optional TAIL checksum: PACKET_RECEIVE_CHECKSUM_EN.
module packet_receive_buffer
  import types::*;
  import packet_types::*;
(
  input  logic            nocclk,
  input  logic            rst,
  input  logic            received_flit_valid,
  output logic            received_flit_ready,
  input  flit_t           received_flit,
  output logic            received_packet_valid,
  input  logic            received_packet_ready,
  output packet_element_t received_packet,
  output logic            received_packet_error
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BODY);

  rx_state_t        state_q, state_d;
  flit_t            head_q, head_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             error_q, error_d;
  logic             live_q, live_d;
  flit_t            stored_body [MAX_BODY];

  logic             accept, head_take, body_take, tail_take, body_we, ck_ok;
  logic [LEN_W-1:0] last_idx;

  assign accept    = received_flit_valid && received_flit_ready;
  assign last_idx  = head_q.length - LEN_W'(1);
  assign head_take = accept && (state_q == S_IDLE) && (received_flit.flittype == HEAD);
  assign body_take = accept && (state_q == S_RECV) && (received_flit.flittype == BODY)
                     && (count_q < last_idx);
  assign tail_take = accept && (state_q == S_RECV) && (received_flit.flittype == TAIL)
                     && (count_q == last_idx);
  assign body_we   = body_take || tail_take;

`ifdef PACKET_RECEIVE_CHECKSUM_EN
  packet_receive_checksum u_checksum (
    .nocclk   (nocclk),
    .rst      (rst),
    .clear    (head_take),
    .update   (head_take || body_take),
    .data     (received_flit.payload),
    .expected (received_flit.payload[7:0]),
    .match    (ck_ok)
  );
`else
  assign ck_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    count_d = count_q;
    error_d = 1'b0;
    live_d  = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (head_take) begin
          head_d  = received_flit;
          count_d = '0;
          if (received_flit.length == '0) begin
            state_d = S_DONE;
          end else if (received_flit.length > MAX_LEN) begin
            error_d = 1'b1;
          end else begin
            state_d = S_RECV;
          end
        end else if (accept && (received_flit.flittype != NOPE)) begin
          error_d = 1'b1;
        end
      end
      S_RECV: begin
        if (body_take) begin
          count_d = count_q + LEN_W'(1);
        end else if (tail_take) begin
          count_d = count_q + LEN_W'(1);
          if (ck_ok) begin
            state_d = S_DONE;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end else if (accept && (received_flit.flittype != NOPE)) begin
          // the offending flit is dropped, even a HEAD
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (received_packet_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      count_q <= count_d;
      error_q <= error_d;
      live_q  <= live_d;
    end
  end

  for (genvar gi = 0; gi < MAX_BODY; gi++) begin : g_body
    flit_t entry_q, entry_d;

    always_comb begin
      entry_d = entry_q;
      if (body_we && (count_q == LEN_W'(gi))) begin
        entry_d = received_flit;
      end
    end

    always_ff @(posedge nocclk or posedge rst) begin
      if (rst) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign stored_body[gi] = entry_q;
  end

  assign received_flit_ready   = live_q && (state_q != S_DONE);
  assign received_packet_valid = (state_q == S_DONE);
  assign received_packet_error = error_q;

  always_comb begin
    received_packet.head  = head_q;
    received_packet.count = count_q;
    for (int i = 0; i < MAX_BODY; i++) begin
      received_packet.body[i] = stored_body[i];
    end
  end
endmodule

// File: tb/tb_packet_receive_buffer.sv
// Randomized bench for packet_receive_buffer against a queue-based packet model.
// Define PACKET_RECEIVE_CHECKSUM_EN for both bench and RTL to check the checksum build.
module tb_packet_receive_buffer;
  import types::*;
  import packet_types::*;

  logic            nocclk = 1'b0;
  logic            rst = 1'b0;
  logic            received_flit_valid;
  logic            received_flit_ready;
  flit_t           received_flit;
  logic            received_packet_valid;
  logic            received_packet_ready;
  packet_element_t received_packet;
  logic            received_packet_error;

  packet_receive_buffer dut (
    .nocclk                (nocclk),
    .rst                   (rst),
    .received_flit_valid   (received_flit_valid),
    .received_flit_ready   (received_flit_ready),
    .received_flit         (received_flit),
    .received_packet_valid (received_packet_valid),
    .received_packet_ready (received_packet_ready),
    .received_packet       (received_packet),
    .received_packet_error (received_packet_error)
  );

  always #5 nocclk = ~nocclk;

  int total = 0;
  int bad   = 0;

  // model: pending stimulus, packet under assembly, packet on offer
  flit_t src_q[$];
  bit    m_init, m_have, m_collect, m_err;
  flit_t m_head, c_head;
  flit_t m_body[$];
  flit_t c_body[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xor_bytes(input logic [31:0] p);
    return p[7:0] ^ p[15:8] ^ p[23:16] ^ p[31:24];
  endfunction

  function automatic flit_t mk_flit(input logic [1:0] ty, input int len, input logic [31:0] pl);
    flit_t f;
    f.flittype = ty;
    f.src_id   = 8'($urandom);
    f.dst_id   = 8'($urandom);
    f.length   = 4'(len);
    f.payload  = pl;
    return f;
  endfunction

  function automatic bit checksum_ok(input flit_t tail);
`ifdef PACKET_RECEIVE_CHECKSUM_EN
    logic [7:0] x;
    x = xor_bytes(c_head.payload);
    for (int i = 0; i < c_body.size(); i++) x = x ^ xor_bytes(c_body[i].payload);
    return x == tail.payload[7:0];
`else
    return tail.length == tail.length;
`endif
  endfunction

  task automatic absorb(input flit_t f, output bit err);
    int len;
    err = 1'b0;
    if (f.flittype == NOPE) return;
    if (!m_collect) begin
      if (f.flittype != HEAD) err = 1'b1;
      else if (f.length == 0) begin
        m_have = 1'b1; m_head = f; m_body.delete();
      end else if (int'(f.length) > MAX_BODY) err = 1'b1;
      else begin
        m_collect = 1'b1; c_head = f; c_body.delete();
      end
    end else begin
      len = int'(c_head.length);
      if (f.flittype == BODY && c_body.size() + 1 < len) begin
        c_body.push_back(f);
      end else if (f.flittype == TAIL && c_body.size() + 1 == len) begin
        m_collect = 1'b0;
        if (checksum_ok(f)) begin
          c_body.push_back(f);
          m_have = 1'b1; m_head = c_head; m_body = c_body;
        end else err = 1'b1;
      end else begin
        m_collect = 1'b0;
        err = 1'b1;
      end
    end
  endtask

  // one clock: drive at negedge, check registered outputs, advance the model
  task automatic step(input int gap_pct, input int rdy_pct);
    bit    m_ready, fire, err_n;
    flit_t f;
    if (src_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      received_flit_valid = 1'b1;
      received_flit       = src_q[0];
    end else begin
      received_flit_valid = 1'b0;
      received_flit       = mk_flit(2'($urandom), $urandom_range(0, 15), $urandom);
    end
    received_packet_ready = ($urandom_range(0, 99) < rdy_pct);
    #1;
    m_ready = m_init && !m_have;
    check_eq("flit_ready", 64'(received_flit_ready), 64'(m_ready));
    check_eq("pkt_valid", 64'(received_packet_valid), 64'(m_have));
    check_eq("pkt_error", 64'(received_packet_error), 64'(m_err));
    if (m_have) begin
      check_eq("pkt_count", 64'(received_packet.count), 64'(m_body.size()));
      check_eq("pkt_head", 64'(received_packet.head), 64'(m_head));
      for (int i = 0; i < m_body.size(); i++)
        check_eq("pkt_body", 64'(received_packet.body[i]), 64'(m_body[i]));
    end
    fire  = received_flit_valid && m_ready;
    err_n = 1'b0;
    if (m_have && received_packet_ready) m_have = 1'b0;
    if (fire) begin
      f = src_q.pop_front();
      absorb(f, err_n);
    end
    m_err = err_n;
    @(negedge nocclk);
  endtask

  task automatic run(input int n, input int gap_pct, input int rdy_pct);
    for (int i = 0; i < n; i++) step(gap_pct, rdy_pct);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    received_flit_valid   = 1'b0;
    received_packet_ready = 1'b0;
    #1;
    check_eq("rst_ready", 64'(received_flit_ready), 64'd0);
    check_eq("rst_valid", 64'(received_packet_valid), 64'd0);
    check_eq("rst_error", 64'(received_packet_error), 64'd0);
    check_eq("rst_count", 64'(received_packet.count), 64'd0);
    check_eq("rst_head", 64'(received_packet.head), 64'd0);
    check_eq("rst_body0", 64'(received_packet.body[0]), 64'd0);
    @(negedge nocclk);
    check_eq("rst_ready_held", 64'(received_flit_ready), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rel_ready", 64'(received_flit_ready), 64'd0);
    m_init = 1'b1; m_have = 1'b0; m_collect = 1'b0; m_err = 1'b0;
    @(negedge nocclk);
  endtask

  // well-formed packet with a correct checksum; flip_ck corrupts the TAIL byte
  task automatic push_packet(input int len, input bit flip_ck);
    flit_t      f;
    logic [7:0] x;
    f = mk_flit(HEAD, len, $urandom);
    x = xor_bytes(f.payload);
    src_q.push_back(f);
    for (int i = 0; i < len; i++) begin
      f = mk_flit((i == len - 1) ? TAIL : BODY, $urandom_range(0, 15), $urandom);
      if (i == len - 1) f.payload[7:0] = x ^ {7'd0, flip_ck};
      else x = x ^ xor_bytes(f.payload);
      src_q.push_back(f);
    end
  endtask

  task automatic push_random_packet();
    flit_t      p[$];
    flit_t      f;
    logic [7:0] x;
    int         len, nb, idx;
    len = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
    nb  = (len > MAX_BODY) ? $urandom_range(0, 3) : len;
    f = mk_flit(HEAD, len, $urandom);
    x = xor_bytes(f.payload);
    p.push_back(f);
    for (int i = 0; i < nb; i++) begin
      f = mk_flit((i == nb - 1) ? TAIL : BODY, $urandom_range(0, 15), $urandom);
      if (i == nb - 1) f.payload[7:0] = x ^ {7'd0, ($urandom_range(0, 9) == 0)};
      else x = x ^ xor_bytes(f.payload);
      p.push_back(f);
    end
    if ($urandom_range(0, 7) == 0) begin
      idx = $urandom_range(0, p.size() - 1);
      f = p[idx];
      f.flittype = 2'($urandom_range(0, 3));
      p[idx] = f;
    end
    if ($urandom_range(0, 3) == 0)
      p.insert($urandom_range(0, p.size()), mk_flit(NOPE, 0, $urandom));
    foreach (p[i]) src_q.push_back(p[i]);
  endtask

  initial begin
    received_flit_valid   = 1'b0;
    received_packet_ready = 1'b0;
    received_flit         = '0;
    #2;
    apply_reset();

    // normal packet; head payload makes the checksum come out to 0xA3
    src_q.push_back(mk_flit(HEAD, 3, 32'h0000_00A0));
    src_q.push_back(mk_flit(BODY, 0, 32'h0000_00A1));
    src_q.push_back(mk_flit(BODY, 0, 32'h0000_00A2));
    src_q.push_back(mk_flit(TAIL, 0, 32'h0000_00A3));
    run(8, 0, 100);

    // head-only, maximum length, overlong length
    src_q.push_back(mk_flit(HEAD, 0, $urandom));
    run(4, 0, 100);
    push_packet(MAX_BODY, 1'b0);
    run(14, 0, 100);
    src_q.push_back(mk_flit(HEAD, 9, $urandom));
    run(3, 0, 100);

    // backpressure with a HEAD waiting behind the held packet
    push_packet(2, 1'b0);
    src_q.push_back(mk_flit(HEAD, 0, $urandom));
    run(10, 0, 0);
    run(6, 0, 100);

    // early TAIL, then BODY while idle followed by a good packet
    src_q.push_back(mk_flit(HEAD, 3, $urandom));
    src_q.push_back(mk_flit(BODY, 0, $urandom));
    src_q.push_back(mk_flit(TAIL, 0, $urandom));
    run(6, 0, 100);
    src_q.push_back(mk_flit(BODY, 0, $urandom));
    push_packet(2, 1'b0);
    run(8, 0, 100);

    // reset after 2 of 4 flits, then a fresh packet
    push_packet(3, 1'b0);
    run(2, 0, 100);
    apply_reset();
    src_q.delete();
    push_packet(3, 1'b0);
    run(8, 0, 100);

    // bit-flipped checksum: dropped with the macro, delivered without
    push_packet(2, 1'b1);
    run(7, 0, 100);

    // randomized traffic with gaps, backpressure and malformed packets
    for (int i = 0; i < 3000; i++) begin
      if (src_q.size() < 4) push_random_packet();
      step(25, 60);
    end
    run(30, 0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
